// File: rtl/occupancy_counter.sv
// occupancy_counter: two-beam entry/exit detector with debounced sensors and a saturating
// occupancy count that drives a seven-segment digit decoder.
module occupancy_counter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_COUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensA,
  input  logic       sensB,
  output logic [3:0] Q,
  output logic       full,
  output logic       empty,
  output logic       enter_pulse,
  output logic       exit_pulse
);
  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;
  // Bit 1 carries the outer sensor A, bit 0 the inner sensor B.
  logic [1:0] s1_q, s2_q, clean_q, clean_d;
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];
  state_t state_q, state_d;
  logic [3:0] q_q, q_d;
  logic enter_q, enter_d, exit_q, exit_d;
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == 16'(DEBOUNCE_CYCLES - 1)) clean_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end
  always_comb begin
    state_d = IDLE;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    case (state_q)
      IDLE: state_d = clean_q == 2'b10 ? EN1 : clean_q == 2'b01 ? EX1 : IDLE;
      EN1:  state_d = clean_q == 2'b11 ? EN2 : clean_q == 2'b10 ? EN1 : IDLE;
      EN2:  state_d = clean_q == 2'b01 ? EN3 : clean_q == 2'b10 ? EN1 : clean_q == 2'b11 ? EN2 : IDLE;
      EN3: begin
        state_d = clean_q == 2'b11 ? EN2 : clean_q == 2'b01 ? EN3 : IDLE;
        enter_d = clean_q == 2'b00;
      end
      EX1:  state_d = clean_q == 2'b11 ? EX2 : clean_q == 2'b01 ? EX1 : IDLE;
      EX2:  state_d = clean_q == 2'b10 ? EX3 : clean_q == 2'b01 ? EX1 : clean_q == 2'b11 ? EX2 : IDLE;
      EX3: begin
        state_d = clean_q == 2'b11 ? EX2 : clean_q == 2'b10 ? EX3 : IDLE;
        exit_d  = clean_q == 2'b00;
      end
      default: state_d = IDLE;
    endcase
    q_d = enter_d && q_q < 4'(MAX_COUNT) ? q_q + 4'd1 :
          exit_d && q_q != 4'd0 ? q_q - 4'd1 : q_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      clean_q <= '0;
      cnt_q   <= '{default: '0};
      state_q <= IDLE;
      q_q     <= '0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      s1_q    <= {sensA, sensB};
      s2_q    <= s1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      q_q     <= q_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
    end
  end
  assign Q           = q_q;
  assign full        = q_q == 4'(MAX_COUNT);
  assign empty       = q_q == 4'd0;
  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
endmodule

// File: tb/tb_occupancy_counter.sv
// tb_occupancy_counter: phase-table, hand-written corner sequences and randomized
// passages checked against a passage-progress reference model.
module tb_occupancy_counter;
  localparam int DC = 4;
  localparam int MAXC = 8;
  logic clk = 1'b0, reset = 1'b1, sensA = 1'b0, sensB = 1'b0;
  logic [3:0] Q;
  logic full, empty, enter_pulse, exit_pulse;
  int vecs = 0, miss = 0, tot_ne = 0, tot_nx = 0;
  int prog = 0, mq = 0;
  typedef struct {logic [1:0] ab; int ne; int nx; int q;} vec_t;
  vec_t tbl[$];
  occupancy_counter #(.DEBOUNCE_CYCLES(DC), .MAX_COUNT(MAXC)) dut (
    .clk(clk), .reset(reset), .sensA(sensA), .sensB(sensB), .Q(Q), .full(full),
    .empty(empty), .enter_pulse(enter_pulse), .exit_pulse(exit_pulse));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (enter_pulse) tot_ne++;
    if (exit_pulse) tot_nx++;
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset;
    reset = 1'b1;
    {sensA, sensB} = 2'b00;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask
  task automatic row(input string nm, input logic [1:0] ab, input int hold,
                     input int ene, input int enx, input int eq);
    int b0, b1;
    b0 = tot_ne;
    b1 = tot_nx;
    {sensA, sensB} = ab;
    tick(hold);
    chk({nm, ".enter"}, tot_ne - b0, ene);
    chk({nm, ".exit"}, tot_nx - b1, enx);
    chk({nm, ".Q"}, Q, eq);
    chk({nm, ".full"}, full, eq == MAXC);
    chk({nm, ".empty"}, empty, eq == 0);
  endtask
  function automatic void add(input logic [1:0] ab, input int ne, input int nx, input int q);
    vec_t v;
    v.ab = ab; v.ne = ne; v.nx = nx; v.q = q;
    tbl.push_back(v);
  endfunction
  // Position along a passage in its own direction: outer only, both, inner only, clear.
  function automatic int pos(input logic x, input logic y);
    return {x, y} == 2'b10 ? 1 : {x, y} == 2'b11 ? 2 : {x, y} == 2'b01 ? 3 : 0;
  endfunction
  task automatic mstep(input logic [1:0] ab, output int ee, output int ex);
    int s, k, n;
    ee = 0;
    ex = 0;
    if (prog != 0) begin
      s = prog > 0 ? 1 : -1;
      k = prog * s;
      n = s > 0 ? pos(ab[1], ab[0]) : pos(ab[0], ab[1]);
      if (n == k) prog = prog;
      else if (n == k + 1) prog = s * (k + 1);
      else if (n == k - 1 && k >= 2) prog = s * (k - 1);
      else begin
        if (k == 3 && n == 0) begin
          if (s > 0) ee = 1;
          else ex = 1;
        end
        prog = 0;
      end
    end
    if (prog == 0) prog = ab == 2'b10 ? 1 : ab == 2'b01 ? -1 : 0;
    if (ee == 1 && mq < MAXC) mq++;
    if (ex == 1 && mq > 0) mq--;
  endtask
  initial begin
    int b0, b1, ee, ex, ri, dir, hold;
    logic [1:0] ring [4];
    logic [1:0] ab;
    ring[0] = 2'b00; ring[1] = 2'b10; ring[2] = 2'b11; ring[3] = 2'b01;
    // entry, exit, exit at zero, entry abort
    add(2'b10,0,0,0); add(2'b11,0,0,0); add(2'b01,0,0,0); add(2'b00,1,0,1);
    add(2'b01,0,0,1); add(2'b11,0,0,1); add(2'b10,0,0,1); add(2'b00,0,1,0);
    add(2'b01,0,0,0); add(2'b11,0,0,0); add(2'b10,0,0,0); add(2'b00,0,1,0);
    add(2'b10,0,0,0); add(2'b00,0,0,0);
    // backtracking entries via EN2->EN1 and EN3->EN2
    add(2'b10,0,0,0); add(2'b11,0,0,0); add(2'b10,0,0,0); add(2'b11,0,0,0);
    add(2'b01,0,0,0); add(2'b00,1,0,1);
    add(2'b10,0,0,1); add(2'b11,0,0,1); add(2'b01,0,0,1); add(2'b11,0,0,1);
    add(2'b01,0,0,1); add(2'b00,1,0,2);
    // EN3 abort on 10, EN2 abort, direct 10->01 crossover
    add(2'b10,0,0,2); add(2'b11,0,0,2); add(2'b01,0,0,2); add(2'b10,0,0,2); add(2'b00,0,0,2);
    add(2'b10,0,0,2); add(2'b11,0,0,2); add(2'b00,0,0,2);
    add(2'b10,0,0,2); add(2'b01,0,0,2); add(2'b00,0,0,2);
    // backtracking exit, EX3 abort, then two entries up to 3
    add(2'b01,0,0,2); add(2'b11,0,0,2); add(2'b01,0,0,2); add(2'b11,0,0,2);
    add(2'b10,0,0,2); add(2'b00,0,1,1);
    add(2'b01,0,0,1); add(2'b11,0,0,1); add(2'b10,0,0,1); add(2'b01,0,0,1); add(2'b00,0,0,1);
    add(2'b10,0,0,1); add(2'b11,0,0,1); add(2'b01,0,0,1); add(2'b00,1,0,2);
    add(2'b10,0,0,2); add(2'b11,0,0,2); add(2'b01,0,0,2); add(2'b00,1,0,3);
    tick(2);
    chk("reset.Q", Q, 0);
    chk("reset.full", full, 0);
    chk("reset.empty", empty, 1);
    chk("reset.pulses", {enter_pulse, exit_pulse}, 0);
    reset = 1'b0;
    tick(1);
    foreach (tbl[i]) row($sformatf("tbl%0d", i), tbl[i].ab, 10, tbl[i].ne, tbl[i].nx, tbl[i].q);
    // Reset in the middle of an entry: asynchronous clear, passage abandoned.
    row("mid.10", 2'b10, 10, 0, 0, 3);
    row("mid.11", 2'b11, 10, 0, 0, 3);
    reset = 1'b1;
    #1;
    chk("mid.async_Q", Q, 0);
    chk("mid.async_empty", empty, 1);
    tick(2);
    reset = 1'b0;
    row("mid.01", 2'b01, 10, 0, 0, 0);
    row("mid.00", 2'b00, 10, 0, 0, 0);
    // Exact event latency: pulse and Q land DC+3 edges after the raw change.
    do_reset;
    row("lat.10", 2'b10, 10, 0, 0, 0);
    row("lat.11", 2'b11, 10, 0, 0, 0);
    row("lat.01", 2'b01, 10, 0, 0, 0);
    {sensA, sensB} = 2'b00;
    tick(DC + 2);
    chk("lat.early_pulse", enter_pulse, 0);
    chk("lat.early_Q", Q, 0);
    tick(1);
    chk("lat.pulse", enter_pulse, 1);
    chk("lat.exit", exit_pulse, 0);
    chk("lat.Q", Q, 1);
    chk("lat.empty", empty, 0);
    tick(1);
    chk("lat.pulse_end", enter_pulse, 0);
    // Short glitches: 2 cycles on A from idle, DC-1 cycles on B while in EN3.
    b0 = tot_ne; b1 = tot_nx;
    sensA = 1'b1; tick(2); sensA = 1'b0; tick(15);
    chk("glitchA.pulses", tot_ne - b0 + tot_nx - b1, 0);
    row("glitchB.10", 2'b10, 10, 0, 0, 1);
    row("glitchB.11", 2'b11, 10, 0, 0, 1);
    row("glitchB.01", 2'b01, 10, 0, 0, 1);
    b0 = tot_ne;
    sensB = 1'b0; tick(DC - 1); sensB = 1'b1; tick(12);
    chk("glitchB.enter", tot_ne - b0, 0);
    chk("glitchB.Q", Q, 1);
    row("glitchB.00", 2'b00, 10, 1, 0, 2);
    // Saturation at MAX_COUNT with nine entries.
    do_reset;
    for (int i = 1; i <= MAXC + 1; i++) begin
      row($sformatf("sat%0d.10", i), 2'b10, 9, 0, 0, i - 1 > MAXC ? MAXC : i - 1);
      row($sformatf("sat%0d.11", i), 2'b11, 9, 0, 0, i - 1 > MAXC ? MAXC : i - 1);
      row($sformatf("sat%0d.01", i), 2'b01, 9, 0, 0, i - 1 > MAXC ? MAXC : i - 1);
      row($sformatf("sat%0d.00", i), 2'b00, 9, 1, 0, i > MAXC ? MAXC : i);
    end
    // Randomized phases against the passage model.
    do_reset;
    prog = 0; mq = 0; ri = 0; dir = 1;
    for (int i = 0; i < 300; i++) begin
      if (ri == 0) dir = $urandom_range(0, 1) ? 1 : 3;
      ri = $urandom_range(0, 3) != 0 ? (ri + dir) % 4 : int'($urandom_range(0, 3));
      ab = ring[ri];
      hold = $urandom_range(DC + 4, DC + 8);
      mstep(ab, ee, ex);
      row($sformatf("rnd%0d", i), ab, hold, ee, ex, mq);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
